alu_word_sequencer: RTL and testbench

- Multi-pass operation sequencer that sits between the instruction decoder, the register file and the 8-bit combinational ALU.
- Executes the three Z8 operations that need two ALU passes: INCW and DECW on a register pair, and DA on a single register.
- Drives the ALU's mode, operand and flag inputs, consumes its result and result flags, writes the results back, and returns final flags to the flag register.

---
 rtl/alu_word_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_word_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_word_sequencer                                                         |
// | Two-pass ALU sequencer for Z8 INCW/DECW (register pair) and DA (register). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_word_sequencer #(
  // Default codes; override to match the ALU's mode table.
  parameter logic [4:0] MODE_INC  = 5'h08,
  parameter logic [4:0] MODE_INCW = 5'h09,
  parameter logic [4:0] MODE_DEC  = 5'h0A,
  parameter logic [4:0] MODE_DECW = 5'h0B,
  parameter logic [4:0] MODE_DA   = 5'h0C,
  parameter logic [4:0] MODE_DA_H = 5'h0D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [1:0] op,
  input  logic [7:0] reg_addr,
  input  logic [7:0] flags_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] flags_out,
  output logic [7:0] rf_addr,
  output logic       rf_rd_en,
  input  logic [7:0] rf_rdata,
  output logic       rf_wr_en,
  output logic [7:0] rf_wdata,
  output logic [4:0] alu_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_flags,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_out_flags
);

  localparam logic [1:0] OP_INCW = 2'd0;
  localparam logic [1:0] OP_DECW = 2'd1;
  localparam logic [1:0] OP_DA   = 2'd2;

  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 5;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RD_LO = 4'd1;
  localparam logic [3:0] S_EX_LO = 4'd2;
  localparam logic [3:0] S_RD_HI = 4'd3;
  localparam logic [3:0] S_EX_HI = 4'd4;
  localparam logic [3:0] S_DA_RD = 4'd5;
  localparam logic [3:0] S_DA1   = 4'd6;
  localparam logic [3:0] S_DA2   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0] state_q, state_d;
  logic [1:0] op_q;
  logic [7:0] addr_q, flags_q, res_q, f1_q, flags_out_q;

  logic       w_accept;
  logic [7:0] w_lo_addr, w_hi_addr, w_da_final, w_da_flags;

  assign w_accept   = start_valid && (state_q == S_IDLE);
  assign w_lo_addr  = addr_q | 8'h01;
  assign w_hi_addr  = addr_q & 8'hFE;
  // The ALU's low nibble in the DA high pass is not trusted; keep the first-pass nibble.
  assign w_da_final = {alu_out[7:4], res_q[3:0]};

  always_comb begin
    w_da_flags         = alu_out_flags;
    w_da_flags[FLAG_Z] = (w_da_final == 8'h00);
    w_da_flags[FLAG_S] = w_da_final[7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          case (op)
            OP_INCW, OP_DECW: state_d = S_RD_LO;
            OP_DA:            state_d = S_DA_RD;
            default:          state_d = S_DONE;
          endcase
        end
      end
      S_RD_LO: state_d = S_EX_LO;
      S_EX_LO: state_d = S_RD_HI;
      S_RD_HI: state_d = S_EX_HI;
      S_EX_HI: state_d = S_DONE;
      S_DA_RD: state_d = S_DA1;
      S_DA1:   state_d = S_DA2;
      S_DA2:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= 2'd0;
      addr_q      <= 8'h00;
      flags_q     <= 8'h00;
      res_q       <= 8'h00;
      f1_q        <= 8'h00;
      flags_out_q <= 8'h00;
    end else begin
      if (w_accept) begin
        op_q    <= op;
        addr_q  <= reg_addr;
        flags_q <= flags_in;
        if (op == 2'd3) begin
          flags_out_q <= flags_in;
        end
      end
      if (state_q == S_EX_LO || state_q == S_DA1) begin
        res_q <= alu_out;
        f1_q  <= alu_out_flags;
      end
      if (state_q == S_EX_HI) begin
        flags_out_q <= alu_out_flags;
      end
      if (state_q == S_DA2) begin
        flags_out_q <= w_da_flags;
      end
    end
  end

  always_comb begin
    start_ready = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    flags_out   = flags_out_q;
    rf_addr     = 8'h00;
    rf_rd_en    = 1'b0;
    rf_wr_en    = 1'b0;
    rf_wdata    = 8'h00;
    alu_mode    = 5'd0;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_flags   = 8'h00;
    case (state_q)
      S_RD_LO: begin
        rf_rd_en = 1'b1;
        rf_addr  = w_lo_addr;
      end
      S_EX_LO: begin
        alu_mode  = (op_q == OP_DECW) ? MODE_DEC : MODE_INC;
        alu_a     = rf_rdata;
        alu_flags = flags_q;
        rf_wr_en  = 1'b1;
        rf_addr   = w_lo_addr;
        rf_wdata  = alu_out;
      end
      S_RD_HI: begin
        rf_rd_en = 1'b1;
        rf_addr  = w_hi_addr;
      end
      S_EX_HI: begin
        alu_mode  = (op_q == OP_DECW) ? MODE_DECW : MODE_INCW;
        alu_a     = rf_rdata;
        alu_b     = res_q;
        alu_flags = f1_q;
        rf_wr_en  = 1'b1;
        rf_addr   = w_hi_addr;
        rf_wdata  = alu_out;
      end
      S_DA_RD: begin
        rf_rd_en = 1'b1;
        rf_addr  = addr_q;
      end
      S_DA1: begin
        alu_mode  = MODE_DA;
        alu_a     = rf_rdata;
        alu_flags = flags_q;
      end
      S_DA2: begin
        alu_mode  = MODE_DA_H;
        alu_a     = res_q;
        alu_flags = f1_q;
        rf_wr_en  = 1'b1;
        rf_addr   = addr_q;
        rf_wdata  = w_da_final;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_word_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_word_sequencer                                                      |
// | Scoreboard bench with register-file and Z8-style ALU models.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_word_sequencer;

  localparam logic [4:0] M_INC  = 5'h08;
  localparam logic [4:0] M_INCW = 5'h09;
  localparam logic [4:0] M_DEC  = 5'h0A;
  localparam logic [4:0] M_DECW = 5'h0B;
  localparam logic [4:0] M_DA   = 5'h0C;
  localparam logic [4:0] M_DA_H = 5'h0D;

  localparam int FC = 7;
  localparam int FZ = 6;
  localparam int FS = 5;
  localparam int FV = 4;
  localparam int FD = 3;
  localparam int FH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [1:0] op = 2'd0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] flags_in = 8'h00;
  logic       busy, done;
  logic [7:0] flags_out, rf_addr, rf_wdata, alu_a, alu_b, alu_flags;
  logic       rf_rd_en, rf_wr_en;
  logic [7:0] rf_rdata = 8'h00;
  logic [4:0] alu_mode;
  logic [7:0] alu_out, alu_out_flags;

  alu_word_sequencer dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .reg_addr(reg_addr), .flags_in(flags_in),
    .busy(busy), .done(done), .flags_out(flags_out),
    .rf_addr(rf_addr), .rf_rd_en(rf_rd_en), .rf_rdata(rf_rdata),
    .rf_wr_en(rf_wr_en), .rf_wdata(rf_wdata),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_flags(alu_flags),
    .alu_out(alu_out), .alu_out_flags(alu_out_flags)
  );

  always #5 clk = ~clk;

  // Register file: one-cycle read latency, preload port for stimulus.
  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_wr_en) mem[rf_addr] <= rf_wdata;
    if (rf_rd_en) rf_rdata <= mem[rf_addr];
  end

  // ALU model. Word carries come from operand b; the DA high pass leaves Z/S
  // stale and scrambles its low nibble, so the sequencer must fix both.
  logic t_c;
  always_comb begin
    alu_out       = 8'h00;
    alu_out_flags = alu_flags;
    t_c           = 1'b0;
    case (alu_mode)
      M_INC: begin
        alu_out = alu_a + 8'd1;
        alu_out_flags[FZ] = (alu_out == 8'h00);
        alu_out_flags[FS] = alu_out[7];
        alu_out_flags[FV] = (alu_a == 8'h7F);
      end
      M_INCW: begin
        t_c = (alu_b == 8'h00);
        alu_out = alu_a + {7'd0, t_c};
        alu_out_flags[FZ] = alu_flags[FZ] & (alu_out == 8'h00);
        alu_out_flags[FS] = alu_out[7];
        alu_out_flags[FV] = t_c & (alu_a == 8'h7F);
      end
      M_DEC: begin
        alu_out = alu_a - 8'd1;
        alu_out_flags[FZ] = (alu_out == 8'h00);
        alu_out_flags[FS] = alu_out[7];
        alu_out_flags[FV] = (alu_a == 8'h80);
      end
      M_DECW: begin
        t_c = (alu_b == 8'hFF);
        alu_out = alu_a - {7'd0, t_c};
        alu_out_flags[FZ] = alu_flags[FZ] & (alu_out == 8'h00);
        alu_out_flags[FS] = alu_out[7];
        alu_out_flags[FV] = t_c & (alu_a == 8'h80);
      end
      M_DA: begin
        if (!alu_flags[FD]) begin
          alu_out = alu_a + ((alu_flags[FH] || alu_a[3:0] > 4'd9) ? 8'h06 : 8'h00);
          alu_out_flags[FC] = alu_flags[FC] | (alu_a > 8'h99);
        end else begin
          alu_out = alu_a - (alu_flags[FH] ? 8'h06 : 8'h00);
        end
      end
      M_DA_H: begin
        if (!alu_flags[FD]) alu_out = alu_a + (alu_flags[FC] ? 8'h60 : 8'h00);
        else                alu_out = alu_a - (alu_flags[FC] ? 8'h60 : 8'h00);
        alu_out[3:0] = ~alu_out[3:0];
      end
      default: ;
    endcase
  end

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] f; int lat; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int  aq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_acc = 0, n_done = 0, n_rd = 0, last_done_cyc = 0;
  bit hold_chk = 1'b0;
  logic [7:0] last_flags_exp = 8'h00;
  wr_t m_w;
  dn_t m_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_busy", 32'(start_ready), 32'(!busy));
      if (rf_rd_en || rf_wr_en) chk("rw_excl", 32'(rf_rd_en & rf_wr_en), 32'd0);
      if (rf_rd_en) n_rd++;
      if (start_valid && start_ready) begin
        n_acc++;
        aq.push_back(cyc);
        if (hold_chk) begin
          chk("hold_gap", 32'(cyc - last_done_cyc), 32'd1);
          hold_chk = 1'b0;
        end
      end
      if (rf_wr_en) begin
        if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          m_w = wq.pop_front();
          chk("wr_addr", 32'(rf_addr), 32'(m_w.a));
          chk("wr_data", 32'(rf_wdata), 32'(m_w.d));
        end
      end
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
        if (dq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          m_d = dq.pop_front();
          last_flags_exp = m_d.f;
          chk("flags_out", 32'(flags_out), 32'(m_d.f));
          if (aq.size() != 0) chk("latency", 32'(cyc - aq.pop_front()), 32'(m_d.lat));
        end
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20 && !start_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!start_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_dones(input int target);
    int k;
    for (k = 0; k < 30 && n_done < target; k++) begin
      @(posedge clk); #1;
    end
    if (n_done < target) chk("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] fl);
    int base;
    base = n_done;
    wait_idle();
    start_valid = 1'b1; op = o; reg_addr = a; flags_in = fl;
    @(posedge clk); #1;
    start_valid = 1'b0; op = 2'($urandom); reg_addr = 8'($urandom); flags_in = 8'($urandom);
    wait_dones(base + 1);
  endtask

  task automatic push_word(input bit dec, input logic [7:0] a, input logic [15:0] v,
                           input logic [7:0] fl);
    logic [15:0] r;
    logic [7:0]  f;
    r = dec ? v - 16'd1 : v + 16'd1;
    f = fl;
    f[FZ] = (r == 16'h0000);
    f[FS] = r[15];
    f[FV] = dec ? (v == 16'h8000) : (v == 16'h7FFF);
    wq.push_back(wr_t'{a | 8'h01, r[7:0]});
    wq.push_back(wr_t'{a & 8'hFE, r[15:8]});
    dq.push_back(dn_t'{f, 5});
  endtask

  task automatic word_op(input bit dec, input logic [7:0] a, input logic [15:0] v,
                         input logic [7:0] fl);
    load(a & 8'hFE, v[15:8]);
    load(a | 8'h01, v[7:0]);
    push_word(dec, a, v, fl);
    run_op(dec ? 2'd1 : 2'd0, a, fl);
  endtask

  task automatic da_op(input logic [7:0] a, input logic [7:0] v, input logic [7:0] fl);
    logic       c;
    logic       lo_adj;
    logic [7:0] r, f;
    lo_adj = fl[FH] || (v[3:0] > 4'd9);
    c      = fl[FC] || (v > 8'h99);
    r      = v + (lo_adj ? 8'h06 : 8'h00) + (c ? 8'h60 : 8'h00);
    f = fl;
    f[FC] = c;
    f[FZ] = (r == 8'h00);
    f[FS] = r[7];
    load(a, v);
    wq.push_back(wr_t'{a, r});
    dq.push_back(dn_t'{f, 4});
    run_op(2'd2, a, fl);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(start_ready), 32'd1);
    chk({tag, "_ctl"}, 32'({busy, done, rf_rd_en, rf_wr_en}), 32'd0);
    chk({tag, "_flags"}, 32'(flags_out), 32'd0);
    chk({tag, "_rf"}, 32'({rf_addr, rf_wdata}), 32'd0);
    chk({tag, "_alu"}, {3'd0, alu_mode, alu_a, alu_b, alu_flags}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, base_rd;
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    word_op(1'b0, 8'h20, 16'h12FF, 8'h00);
    word_op(1'b0, 8'h20, 16'h7FFF, 8'h80);
    word_op(1'b0, 8'h20, 16'hFFFF, 8'h8C);
    word_op(1'b1, 8'h20, 16'h0000, 8'h00);
    word_op(1'b1, 8'h21, 16'h0100, 8'h44);
    word_op(1'b1, 8'h32, 16'h8000, 8'h00);

    da_op(8'h60, 8'h9B, 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("flags_hold", 32'(flags_out), 32'(last_flags_exp));
    da_op(8'h61, 8'h00, 8'h00);
    da_op(8'h62, 8'h15, 8'h04);

    // Reserved op: straight to DONE, flags pass through, no register traffic.
    base_rd = n_rd;
    dq.push_back(dn_t'{8'hA5, 1});
    run_op(2'd3, 8'h77, 8'hA5);
    chk("rsvd_no_rd", 32'(n_rd - base_rd), 32'd0);

    // start_valid held through an operation: second accept on first IDLE cycle.
    load(8'h40, 8'h00);
    load(8'h41, 8'hFE);
    push_word(1'b0, 8'h40, 16'h00FE, 8'h00);
    push_word(1'b0, 8'h40, 16'h00FF, 8'h00);
    base = n_acc;
    wait_idle();
    start_valid = 1'b1; op = 2'd0; reg_addr = 8'h40; flags_in = 8'h00;
    for (int k = 0; k < 20 && n_acc < base + 1; k++) begin @(posedge clk); #1; end
    hold_chk = 1'b1;
    for (int k = 0; k < 20 && n_acc < base + 2; k++) begin @(posedge clk); #1; end
    chk("hold_accepts", 32'(n_acc - base), 32'd2);
    start_valid = 1'b0;
    wait_dones(n_done + 1);

    // Reset during EX_HI: low byte stays written, no high write, no done.
    load(8'h50, 8'h12);
    load(8'h51, 8'h34);
    wq.push_back(wr_t'{8'h51, 8'h35});
    base = n_done;
    wait_idle();
    start_valid = 1'b1; op = 2'd0; reg_addr = 8'h50; flags_in = 8'h00;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int k = 0; k < 10 && !(rf_rd_en && rf_addr == 8'h50); k++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk("exhi_wr", 32'({rf_wr_en, rf_addr}), 32'({1'b1, 8'h50}));
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    aq.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("abort_hi", 32'(mem[8'h50]), 32'h12);
    chk("abort_lo", 32'(mem[8'h51]), 32'h35);
    chk("abort_no_done", 32'(n_done - base), 32'd0);

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
